// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from active-low hsync/vsync and tracks timing lock.
// Optional macro VGA_SYNC_ERRCNT_EN enables the saturating err_count counter.
module vga_sync_decoder #(
  parameter int unsigned HPIXELS     = 800,
  parameter int unsigned VLINES      = 521,
  parameter int unsigned HBP         = 144,
  parameter int unsigned HFP         = 784,
  parameter int unsigned VBP         = 31,
  parameter int unsigned VFP         = 511,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  h_pos,
  output logic [9:0]  v_pos,
  output logic        vidon,
  output logic        locked,
  output logic        frame_start,
  output logic [10:0] line_len,
  output logic [7:0]  err_count
);

  localparam logic [10:0] HPIX_L = 11'(HPIXELS);
  localparam logic [10:0] VLIN_L = 11'(VLINES);
  localparam logic [9:0]  TMO_L  = 10'(HPIXELS + 15);
  localparam logic [9:0]  HBP_L  = 10'(HBP);
  localparam logic [9:0]  HFP_L  = 10'(HFP);
  localparam logic [9:0]  VBP_L  = 10'(VBP);
  localparam logic [9:0]  VFP_L  = 10'(VFP);
  localparam logic [3:0]  LOCK_L = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ACQUIRE,
    ST_LOCKED
  } state_e;

  state_e      state_q;
  logic        hs_q;
  logic        vs_q;
  logic [9:0]  h_pos_q;
  logic [9:0]  v_pos_q;
  logic [10:0] line_len_q;
  logic        locked_q;
  logic        frame_start_q;
  logic [3:0]  good_q;
  logic        lines_ok_q;

  logic        hfall;
  logic        vfall;
  logic [10:0] h_inc;
  logic [10:0] v_inc;
  logic [3:0]  good_inc;
  logic        timeout;
  logic        line_bad;
  logic        frame_good;
  logic        frame_bad;
  logic        bad_evt;

  assign hfall    = hs_q & ~hsync;
  assign vfall    = vs_q & ~vsync;
  assign h_inc    = {1'b0, h_pos_q} + 11'd1;
  assign v_inc    = {1'b0, v_pos_q} + 11'd1;
  assign good_inc = good_q + 4'd1;
  assign timeout  = ~hfall & (h_pos_q == TMO_L);
  // The line ending in this cycle is judged before the frame, so a bad
  // closing line also spoils a coincident vsync fall.
  assign line_bad   = (hfall & (h_inc != HPIX_L)) | timeout;
  assign frame_good = vfall & (v_inc == VLIN_L) & lines_ok_q & ~line_bad;
  assign frame_bad  = vfall & ~frame_good;
  assign bad_evt    = line_bad | frame_bad;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= ST_SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_pos_q       <= '0;
      v_pos_q       <= '0;
      line_len_q    <= '0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      good_q        <= '0;
      lines_ok_q    <= 1'b1;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
      // A timeout restarts the position count so it refires every period
      // while the sync stays stuck.
      if (hfall || timeout) h_pos_q <= '0;
      else if (h_pos_q != '1) h_pos_q <= h_pos_q + 10'd1;
      if (hfall) line_len_q <= h_inc;
      if (vfall) v_pos_q <= '0;
      else if (hfall && (v_pos_q != '1)) v_pos_q <= v_pos_q + 10'd1;
      if (vfall) lines_ok_q <= 1'b1;
      else if (line_bad) lines_ok_q <= 1'b0;
      frame_start_q <= 1'b0;

      case (state_q)
        ST_SEARCH: begin
          if (vfall) begin
            state_q <= ST_ACQUIRE;
            good_q  <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (bad_evt) begin
            good_q <= '0;
          end else if (frame_good) begin
            frame_start_q <= 1'b1;
            good_q        <= good_inc;
            if (good_inc == LOCK_L) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (bad_evt) begin
            state_q  <= ST_ACQUIRE;
            locked_q <= 1'b0;
            good_q   <= '0;
          end else if (frame_good) begin
            frame_start_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_SEARCH;
          locked_q <= 1'b0;
          good_q   <= '0;
        end
      endcase
    end
  end

`ifdef VGA_SYNC_ERRCNT_EN
  logic [7:0] err_q;
  logic       lock_lost;

  assign lock_lost = (state_q == ST_LOCKED) & bad_evt;

  always_ff @(posedge clk) begin
    if (clr) err_q <= '0;
    else if (lock_lost && (err_q != '1)) err_q <= err_q + 8'd1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  assign h_pos       = h_pos_q;
  assign v_pos       = v_pos_q;
  assign line_len    = line_len_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign vidon       = locked_q & (h_pos_q > HBP_L) & (h_pos_q < HFP_L) &
                       (v_pos_q > VBP_L) & (v_pos_q < VFP_L);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a shrunken 40x12 raster: vector table, directed
// corner sequences and random sync streams checked against a time-based model.
module tb_vga_sync_decoder;

  localparam int HP   = 40;
  localparam int VL   = 12;
  localparam int HBPP = 8;
  localparam int HFPP = 36;
  localparam int VBPP = 2;
  localparam int VFPP = 10;
  localparam int LF   = 2;
  localparam int HSW  = 5;
  localparam int TMO  = HP + 15;
`ifdef VGA_SYNC_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [9:0]  h_pos;
  logic [9:0]  v_pos;
  logic        vidon;
  logic        locked;
  logic        frame_start;
  logic [10:0] line_len;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .HPIXELS(HP), .VLINES(VL), .HBP(HBPP), .HFP(HFPP),
    .VBP(VBPP), .VFP(VFPP), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .clr(clr), .hsync(hsync), .vsync(vsync),
    .h_pos(h_pos), .v_pos(v_pos), .vidon(vidon), .locked(locked),
    .frame_start(frame_start), .line_len(line_len), .err_count(err_count)
  );

  int tests = 0;
  int fails = 0;
  bit abort = 1'b0;
  int fs_cnt = 0;

  // Reference model: positions are elapsed clock counts since the last line
  // restart; lock is a run length of consecutive good frames.
  int cyc = 0;
  int r_restart = 0;
  int mh = 0, mv = 0, mlen = 0, merr = 0, run = 0;
  bit hsp = 1'b1, vsp = 1'b1, seen = 1'b0, mlock = 1'b0, mfs = 1'b0, lok = 1'b1;

  function automatic void check(string name, int act, int exp);
    if (abort) return;
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      if (fails >= 25) abort = 1'b1;
    end
  endfunction

  function automatic void model_update(bit c, bit hs, bit vs);
    int hb;
    bit hf, vf, to, lbad, fgood;
    if (c) begin
      r_restart = cyc; mh = 0; mv = 0; mlen = 0; merr = 0; run = 0;
      mlock = 0; mfs = 0; seen = 0; lok = 1; hsp = 1; vsp = 1;
      return;
    end
    hb = cyc - 1 - r_restart;
    if (hb > 1023) hb = 1023;
    hf = hsp && !hs;
    vf = vsp && !vs;
    to = !hf && (hb == TMO);
    lbad = (hf && (hb + 1 != HP)) || to;
    fgood = vf && (mv + 1 == VL) && lok && !lbad;
    if (hf) mlen = hb + 1;
    if (hf || to) r_restart = cyc;
    mh = cyc - r_restart;
    if (mh > 1023) mh = 1023;
    if (vf) mv = 0;
    else if (hf && mv < 1023) mv++;
    mfs = 0;
    if (!seen) begin
      if (vf) begin seen = 1; run = 0; end
    end else if (lbad || (vf && !fgood)) begin
      if (mlock && ERR_EN && merr < 255) merr++;
      mlock = 0;
      run = 0;
    end else if (fgood) begin
      run++;
      mfs = 1;
      if (run >= LF) mlock = 1;
    end
    if (vf) lok = 1;
    else if (lbad) lok = 0;
    hsp = hs;
    vsp = vs;
  endfunction

  task automatic step(input bit c, input bit hs, input bit vs);
    bit ev;
    if (abort) return;
    clr = c; hsync = hs; vsync = vs;
    model_update(c, hs, vs);
    @(posedge clk);
    #1;
    cyc++;
    ev = mlock && (mh > HBPP) && (mh < HFPP) && (mv > VBPP) && (mv < VFPP);
    if (frame_start) fs_cnt++;
    check("h_pos", int'(h_pos), mh);
    check("v_pos", int'(v_pos), mv);
    check("vidon", int'(vidon), int'(ev));
    check("locked", int'(locked), int'(mlock));
    check("frame_start", int'(frame_start), int'(mfs));
    check("line_len", int'(line_len), mlen);
    check("err_count", int'(err_count), merr);
  endtask

  // probe 1: fixed-position/vidon boundary checks, probe 2: short-line line_len
  task automatic gen_frame(input int first, input int nlines, input int badl,
                           input int badlen, input int probe);
    int len;
    for (int l = first; l < nlines; l++) begin
      len = (l == badl) ? badlen : HP;
      for (int h = 0; h < len; h++) begin
        step(1'b0, h >= HSW, l >= 2);
        if (probe == 1) begin
          if (l == 5 && h == 29) begin
            check("pos_h29", int'(h_pos), 29);
            check("pos_v5", int'(v_pos), 5);
            check("vidon_mid", int'(vidon), 1);
          end
          if (l == 5 && h == HBPP)     check("vidon_hbp", int'(vidon), 0);
          if (l == 5 && h == HBPP + 1) check("vidon_hbp1", int'(vidon), 1);
          if (l == 5 && h == HFPP - 1) check("vidon_hfp1", int'(vidon), 1);
          if (l == 5 && h == HFPP)     check("vidon_hfp", int'(vidon), 0);
          if (l == VBPP && h == 20)     check("vidon_vbp", int'(vidon), 0);
          if (l == VBPP + 1 && h == 20) check("vidon_vbp1", int'(vidon), 1);
          if (l == VFPP - 1 && h == 20) check("vidon_vfp1", int'(vidon), 1);
          if (l == VFPP && h == 20)     check("vidon_vfp", int'(vidon), 0);
        end
        if (probe == 2 && l == badl + 1 && h == 0) begin
          check("line_len_short", int'(line_len), badlen);
          check("lock_drop_short", int'(locked), 0);
        end
        if (probe == 2 && l == badl + 2 && h == 0)
          check("line_len_after", int'(line_len), HP);
      end
    end
  endtask

  task automatic rand_frames(input int n);
    int nl, sel, kind, len, k;
    for (int f = 0; f < n; f++) begin
      sel = $urandom_range(0, 9);
      nl = (sel == 0) ? VL - 1 : (sel == 1) ? VL + 1 : VL;
      for (int l = 0; l < nl; l++) begin
        kind = $urandom_range(0, 199);
        if (kind <= 1) begin
          k = $urandom_range(60, 130);
          for (int i = 0; i < k; i++) step(1'b0, kind == 0, l >= 2);
        end else begin
          len = (kind < 6) ? $urandom_range(HP - 2, HP + 2) : HP;
          for (int h = 0; h < len; h++) step(1'b0, h >= HSW, l >= 2);
        end
      end
    end
  endtask

  typedef struct {
    int frames;
    int lines;
    int badl;
    int badlen;
    int exp_locked;
    int exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int prev_h, drop_cyc, period;
    bit dropped, second;

    vecs[0] = '{3, VL, -1, HP,     1, 0};
    vecs[1] = '{1, VL,  5, HP - 1, 0, 1};
    vecs[2] = '{2, VL, -1, HP,     0, 1};
    vecs[3] = '{1, VL, -1, HP,     1, 1};
    vecs[4] = '{1, VL - 1, -1, HP, 1, 1};
    vecs[5] = '{1, VL, -1, HP,     0, 2};
    vecs[6] = '{1, VL - 1, -1, HP, 0, 2};
    vecs[7] = '{1, VL, -1, HP,     0, 2};
    vecs[8] = '{1, VL, -1, HP,     0, 2};
    vecs[9] = '{1, VL, -1, HP,     1, 2};

    step(1'b1, 1'b1, 1'b1);
    check("rst_h", int'(h_pos), 0);
    check("rst_v", int'(v_pos), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_len", int'(line_len), 0);

    for (int i = 0; i < 10; i++) begin
      for (int f = 0; f < vecs[i].frames; f++)
        gen_frame(0, vecs[i].lines, vecs[i].badl, vecs[i].badlen, 0);
      check($sformatf("vec%0d_locked", i), int'(locked), vecs[i].exp_locked);
      check($sformatf("vec%0d_err", i), int'(err_count), ERR_EN ? vecs[i].exp_err : 0);
      check($sformatf("vec%0d_len", i), int'(line_len), HP);
    end

    fs_cnt = 0;
    gen_frame(0, VL, -1, HP, 1);
    gen_frame(0, VL, -1, HP, 0);
    check("fs_per_frame", fs_cnt, 2);
    check("still_locked", int'(locked), 1);

    gen_frame(0, VL, 5, HP - 1, 2);
    gen_frame(0, VL, -1, HP, 0);
    gen_frame(0, VL, -1, HP, 0);
    check("relock_wait", int'(locked), 0);
    gen_frame(0, VL, -1, HP, 0);
    check("relock", int'(locked), 1);
    check("err_short", int'(err_count), ERR_EN ? 3 : 0);

    dropped = 0; second = 0; drop_cyc = 0; period = 0;
    prev_h = int'(h_pos);
    for (int i = 0; i < 3 * TMO && !abort; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (!dropped && !locked) begin
        dropped = 1;
        drop_cyc = cyc;
        check("tmo_at", prev_h, TMO);
        check("tmo_h0", int'(h_pos), 0);
      end else if (dropped && !second && h_pos == 0) begin
        second = 1;
        period = cyc - drop_cyc;
      end
      prev_h = int'(h_pos);
    end
    check("tmo_dropped", int'(dropped), 1);
    check("tmo_period", period, TMO + 1);
    check("tmo_err", int'(err_count), ERR_EN ? 4 : 0);

    for (int f = 0; f < 3; f++) gen_frame(0, VL, -1, HP, 0);
    check("relock_tmo", int'(locked), 1);
    gen_frame(0, 6, -1, HP, 0);
    step(1'b1, 1'b1, 1'b1);
    check("clr_locked", int'(locked), 0);
    check("clr_h", int'(h_pos), 0);
    check("clr_v", int'(v_pos), 0);
    check("clr_err", int'(err_count), 0);
    gen_frame(6, VL, -1, HP, 0);
    gen_frame(0, VL, -1, HP, 0);
    gen_frame(0, VL, -1, HP, 0);
    check("clr_nolock", int'(locked), 0);
    gen_frame(0, VL, -1, HP, 0);
    check("clr_relock", int'(locked), 1);

    rand_frames(15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
